// File: rtl/adder_pkg.sv
// Shared types and constants for the keypad-driven adder sequencer.
// Holds the FSM state enum, key codes, operand/sum widths and a digit test helper.
// Imported by the interface, the digit accumulator and the controller top.
package adder_pkg;

  localparam int OPERAND_W       = 12;
  localparam int SUM_W           = 14;
  localparam int NUM_DIGITS_DEF  = 3;
  localparam int ADD_TIMEOUT_DEF = 16;

  localparam logic [3:0] KEY_PLUS = 4'hA;
  localparam logic [3:0] KEY_EQ   = 4'hB;
  localparam logic [3:0] KEY_CLR  = 4'hC;

  typedef enum logic [2:0] {
    ENTER_A,
    ENTER_B,
    START,
    WAIT,
    DONE,
    ERROR
  } state_t;

  function automatic logic is_digit(input logic [3:0] k);
    return k <= 4'd9;
  endfunction

endpackage

// File: rtl/adder_controller_if.sv
// Bundle between keypad source / adder / display and the adder_controller.
// Inputs to the controller: key_valid, key_code, sum_in, valid_in.
// Outputs from the controller: number1/2, start_suma, result, result_ready, error, display_value.
interface adder_controller_if;
  import adder_pkg::*;

  logic                 key_valid;
  logic [3:0]           key_code;
  logic [OPERAND_W-1:0] number1;
  logic [OPERAND_W-1:0] number2;
  logic                 start_suma;
  logic [SUM_W-1:0]     sum_in;
  logic                 valid_in;
  logic [SUM_W-1:0]     result;
  logic                 result_ready;
  logic                 error;
  logic [SUM_W-1:0]     display_value;

  // Environment side: keypad, adder and display.
  modport master (
    output key_valid, key_code, sum_in, valid_in,
    input  number1, number2, start_suma, result, result_ready, error, display_value
  );

  // Controller side.
  modport slave (
    input  key_valid, key_code, sum_in, valid_in,
    output number1, number2, start_suma, result, result_ready, error, display_value
  );

endinterface

// File: rtl/digit_accumulator.sv
// Builds one binary operand from decimal digits: acc = acc*10 + d, at most NUM_DIGITS digits.
// Ports: clk, reset (async active-low), clr/load/push controls, digit in; acc and count out.
// Priority clr > load > push; pushes beyond NUM_DIGITS digits are dropped.
module digit_accumulator
  import adder_pkg::*;
#(
  parameter  int NUM_DIGITS = NUM_DIGITS_DEF,
  localparam int CNT_W      = $clog2(NUM_DIGITS + 1)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 clr,
  input  logic                 load,
  input  logic                 push,
  input  logic [3:0]           digit,
  output logic [OPERAND_W-1:0] acc,
  output logic [CNT_W-1:0]     count
);

  logic [OPERAND_W-1:0] digit_ext;
  logic [OPERAND_W-1:0] acc_x10_d;

  assign digit_ext = {{(OPERAND_W-4){1'b0}}, digit};
  // acc*10 as two shifts; cannot overflow because acc <= 99 whenever a push is accepted.
  assign acc_x10_d = (acc << 3) + (acc << 1) + digit_ext;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc   <= '0;
      count <= '0;
    end else if (clr) begin
      acc   <= '0;
      count <= '0;
    end else if (load) begin
      acc   <= digit_ext;
      count <= CNT_W'(1);
    end else if (push && (count < CNT_W'(NUM_DIGITS))) begin
      acc   <= acc_x10_d;
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/adder_controller.sv
// Sequencer between keypad decoder and adder: collects two decimal operands, fires a
// one-cycle start_suma, waits (with timeout) for the adder's valid and holds the sum.
// Ports: clk, reset (async active-low), bus (slave modport of adder_controller_if).
module adder_controller
  import adder_pkg::*;
#(
  parameter int NUM_DIGITS  = NUM_DIGITS_DEF,
  parameter int ADD_TIMEOUT = ADD_TIMEOUT_DEF
) (
  input  logic               clk,
  input  logic               reset,
  adder_controller_if.slave  bus
);

  localparam int CNT_W = $clog2(NUM_DIGITS + 1);
  localparam int TMR_W = $clog2(ADD_TIMEOUT);

  state_t               state, state_next;
  logic [TMR_W-1:0]     timer;
  logic [OPERAND_W-1:0] a_acc, b_acc;
  logic [CNT_W-1:0]     a_count, b_count;
  logic                 a_clr, a_load, a_push;
  logic                 b_clr, b_push;
  logic                 key_digit, key_plus, key_eq, key_clr;
  logic                 timeout;
  logic [SUM_W-1:0]     result_q;
  logic                 result_ready_q;
  logic                 error_q;

  assign key_digit = bus.key_valid && is_digit(bus.key_code);
  assign key_plus  = bus.key_valid && (bus.key_code == KEY_PLUS);
  assign key_eq    = bus.key_valid && (bus.key_code == KEY_EQ);
  assign key_clr   = bus.key_valid && (bus.key_code == KEY_CLR);
  assign timeout   = (timer == TMR_W'(ADD_TIMEOUT - 1));

  digit_accumulator #(.NUM_DIGITS(NUM_DIGITS)) u_acc_a (
    .clk(clk), .reset(reset), .clr(a_clr), .load(a_load), .push(a_push),
    .digit(bus.key_code), .acc(a_acc), .count(a_count)
  );

  digit_accumulator #(.NUM_DIGITS(NUM_DIGITS)) u_acc_b (
    .clk(clk), .reset(reset), .clr(b_clr), .load(1'b0), .push(b_push),
    .digit(bus.key_code), .acc(b_acc), .count(b_count)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ENTER_A;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    a_clr      = 1'b0;
    a_load     = 1'b0;
    a_push     = 1'b0;
    b_clr      = 1'b0;
    b_push     = 1'b0;
    if (key_clr) begin
      state_next = ENTER_A;
      a_clr      = 1'b1;
      b_clr      = 1'b1;
    end else begin
      unique case (state)
        ENTER_A: begin
          a_push = key_digit;
          if (key_plus && (a_count != '0)) state_next = ENTER_B;
        end
        ENTER_B: begin
          b_push = key_digit;
          if (key_eq && (b_count != '0)) state_next = START;
        end
        START:   state_next = WAIT;
        WAIT: begin
          // A valid arriving on the last allowed cycle still counts.
          if (bus.valid_in)  state_next = DONE;
          else if (timeout)  state_next = ERROR;
        end
        DONE: begin
          // A digit after a result starts a fresh operand A with that digit.
          if (key_digit) begin
            a_load     = 1'b1;
            b_clr      = 1'b1;
            state_next = ENTER_A;
          end
        end
        ERROR:   state_next = ERROR;
        default: state_next = ENTER_A;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)              timer <= '0;
    else if (state == WAIT)  timer <= timer + 1'b1;
    else                     timer <= '0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      result_q       <= '0;
      result_ready_q <= 1'b0;
      error_q        <= 1'b0;
    end else if (key_clr) begin
      result_q       <= '0;
      result_ready_q <= 1'b0;
      error_q        <= 1'b0;
    end else begin
      if (state == WAIT) begin
        if (bus.valid_in) begin
          result_q       <= bus.sum_in;
          result_ready_q <= 1'b1;
        end else if (timeout) begin
          error_q <= 1'b1;
        end
      end
      if ((state == DONE) && key_digit) result_ready_q <= 1'b0;
    end
  end

  // A clear landing in the START cycle suppresses the pulse so an aborted sum never starts.
  assign bus.start_suma   = (state == START) && !key_clr;
  assign bus.number1      = a_acc;
  assign bus.number2      = b_acc;
  assign bus.result       = result_q;
  assign bus.result_ready = result_ready_q;
  assign bus.error        = error_q;

  always_comb begin
    bus.display_value = '0;
    case (state)
      ENTER_A: bus.display_value = {{(SUM_W-OPERAND_W){1'b0}}, a_acc};
      ENTER_B: bus.display_value = {{(SUM_W-OPERAND_W){1'b0}}, b_acc};
      DONE:    bus.display_value = result_q;
      default: bus.display_value = '0;
    endcase
  end

endmodule

// File: tb/tb_adder_controller.sv
module tb_adder_controller;

  typedef struct {
    int a;
    int b;
  } ops_t;

  logic clk;
  logic reset;

  adder_controller_if bus ();

  adder_controller dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int   checks      = 0;
  int   failures    = 0;
  int   start_count = 0;
  ops_t exp_ops[$];
  int   exp_res[$];

  // Adder model controls (written only by the stimulus process).
  bit   respond      = 1'b1;
  int   manual_pulse = 0;
  int   manual_sum   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Adder model: valid three negedges after a sampled start, or a one-off manual pulse.
  initial begin : adder_model
    int resp_cnt;
    int pend_sum;
    int manual_seen;
    resp_cnt     = 0;
    pend_sum     = 0;
    manual_seen  = 0;
    bus.valid_in = 1'b0;
    bus.sum_in   = '0;
    forever begin
      @(negedge clk);
      bus.valid_in = 1'b0;
      if (resp_cnt > 0) begin
        resp_cnt--;
        if (resp_cnt == 0) begin
          bus.valid_in = 1'b1;
          bus.sum_in   = 14'(pend_sum);
        end
      end else if (reset && bus.start_suma && respond) begin
        resp_cnt = 3;
        pend_sum = int'(bus.number1) + int'(bus.number2);
      end
      if (manual_pulse != manual_seen) begin
        manual_seen  = manual_pulse;
        bus.valid_in = 1'b1;
        bus.sum_in   = 14'(manual_sum);
      end
    end
  end

  // Scoreboard monitor: checks operands on each start pulse and the sum on each result.
  initial begin : monitor
    logic prev_start;
    logic prev_rr;
    ops_t o;
    int   r;
    prev_start = 1'b0;
    prev_rr    = 1'b0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        prev_start = 1'b0;
        prev_rr    = 1'b0;
      end else begin
        if (bus.start_suma) begin
          chk("start_consecutive", int'(prev_start), 0);
          if (exp_ops.size() == 0) begin
            chk("unexpected_start", 1, 0);
          end else begin
            o = exp_ops.pop_front();
            chk("number1_at_start", int'(bus.number1), o.a);
            chk("number2_at_start", int'(bus.number2), o.b);
          end
          start_count++;
        end
        if (bus.result_ready && !prev_rr) begin
          if (exp_res.size() == 0) begin
            chk("unexpected_result", 1, 0);
          end else begin
            r = exp_res.pop_front();
            chk("result", int'(bus.result), r);
            chk("display_result", int'(bus.display_value), r);
          end
        end
        prev_start = bus.start_suma;
        prev_rr    = bus.result_ready;
      end
    end
  end

  task automatic press(input logic [3:0] k);
    @(posedge clk);
    #1;
    bus.key_valid = 1'b1;
    bus.key_code  = k;
    @(posedge clk);
    #1;
    bus.key_valid = 1'b0;
  endtask

  task automatic press_seq(input logic [3:0] ks[$]);
    foreach (ks[i]) press(ks[i]);
  endtask

  task automatic settle();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_start(input int prev);
    for (int i = 0; i < 20; i++) begin
      if (start_count != prev) break;
      settle();
    end
    chk("start_seen", start_count, prev + 1);
  endtask

  task automatic wait_rr();
    for (int i = 0; i < 30; i++) begin
      if (bus.result_ready) break;
      settle();
    end
    chk("result_ready_seen", int'(bus.result_ready), 1);
  endtask

  initial begin : stimulus
    int s0;
    int k;
    bus.key_valid = 1'b0;
    bus.key_code  = 4'h0;
    reset = 1'b0;
    #3;
    chk("rst_display", int'(bus.display_value), 0);
    chk("rst_start", int'(bus.start_suma), 0);
    chk("rst_result_ready", int'(bus.result_ready), 0);
    chk("rst_error", int'(bus.error), 0);
    chk("rst_number1", int'(bus.number1), 0);
    repeat (2) @(negedge clk);
    reset = 1'b1;

    // 123 + 456 = 579
    exp_ops.push_back('{123, 456});
    exp_res.push_back(579);
    press_seq('{4'h1, 4'h2, 4'h3});
    settle();
    chk("disp_a_123", int'(bus.display_value), 123);
    press(4'hA);
    settle();
    chk("disp_b_empty", int'(bus.display_value), 0);
    press_seq('{4'h4, 4'h5, 4'h6});
    settle();
    chk("disp_b_456", int'(bus.display_value), 456);
    s0 = start_count;
    press(4'hB);
    wait_start(s0);
    wait_rr();
    repeat (3) settle();
    chk("hold_result", int'(bus.result), 579);
    chk("hold_display", int'(bus.display_value), 579);
    chk("hold_rr", int'(bus.result_ready), 1);
    press(4'hA);
    press(4'hB);
    settle();
    chk("done_ops_ignored", int'(bus.display_value), 579);

    // Digit from DONE starts a new A; 4th digit dropped: 999 + 999 = 1998
    press(4'h9);
    settle();
    chk("done_digit_rr", int'(bus.result_ready), 0);
    chk("done_digit_disp", int'(bus.display_value), 9);
    press_seq('{4'h9, 4'h9, 4'h9});
    settle();
    chk("a_capped_999", int'(bus.display_value), 999);
    exp_ops.push_back('{999, 999});
    exp_res.push_back(1998);
    press_seq('{4'hA, 4'h9, 4'h9, 4'h9});
    s0 = start_count;
    press(4'hB);
    wait_start(s0);
    wait_rr();

    // Operators with no digits are ignored; 0xD ignored
    press(4'hC);
    settle();
    chk("clr_display", int'(bus.display_value), 0);
    chk("clr_rr", int'(bus.result_ready), 0);
    chk("clr_result", int'(bus.result), 0);
    s0 = start_count;
    press_seq('{4'hA, 4'hB, 4'h5});
    settle();
    chk("plus_empty_stays_a", int'(bus.display_value), 5);
    press_seq('{4'hA, 4'hB});
    repeat (4) settle();
    chk("eq_empty_no_start", start_count, s0);
    press_seq('{4'hD, 4'h7});
    settle();
    chk("key_d_ignored", int'(bus.display_value), 7);
    exp_ops.push_back('{5, 7});
    exp_res.push_back(12);
    press(4'hB);
    wait_start(s0);
    wait_rr();

    // Adder never answers: error 16 cycles into WAIT
    respond = 1'b0;
    press(4'hC);
    exp_ops.push_back('{2, 3});
    press_seq('{4'h2, 4'hA, 4'h3});
    s0 = start_count;
    press(4'hB);
    wait_start(s0);
    k = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      k++;
      if (bus.error) break;
    end
    chk("timeout_cycles", k, 17);
    chk("error_set", int'(bus.error), 1);
    press(4'h4);
    settle();
    chk("error_sticky", int'(bus.error), 1);
    chk("error_display", int'(bus.display_value), 0);
    press(4'hC);
    settle();
    chk("error_cleared", int'(bus.error), 0);
    chk("error_clr_disp", int'(bus.display_value), 0);
    press(4'h8);
    settle();
    chk("after_error_enter_a", int'(bus.display_value), 8);

    // Clear during WAIT, then a late valid must be ignored
    press(4'hC);
    exp_ops.push_back('{1, 1});
    press_seq('{4'h1, 4'hA, 4'h1});
    s0 = start_count;
    press(4'hB);
    wait_start(s0);
    repeat (2) settle();
    press(4'hC);
    manual_sum = 100;
    manual_pulse++;
    repeat (4) settle();
    chk("late_valid_rr", int'(bus.result_ready), 0);
    chk("late_valid_result", int'(bus.result), 0);
    chk("late_valid_display", int'(bus.display_value), 0);
    chk("clear_aborts_start", start_count, s0 + 1);

    // Async reset in the middle of WAIT
    exp_ops.push_back('{3, 4});
    press_seq('{4'h3, 4'hA, 4'h4});
    s0 = start_count;
    press(4'hB);
    wait_start(s0);
    repeat (2) settle();
    chk("wait_number1_frozen", int'(bus.number1), 3);
    #2;
    reset = 1'b0;
    #1;
    chk("async_rst_number1", int'(bus.number1), 0);
    chk("async_rst_number2", int'(bus.number2), 0);
    chk("async_rst_display", int'(bus.display_value), 0);
    chk("async_rst_start", int'(bus.start_suma), 0);
    chk("async_rst_error", int'(bus.error), 0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    press(4'h6);
    settle();
    chk("resume_enter_a", int'(bus.display_value), 6);

    chk("ops_queue_empty", exp_ops.size(), 0);
    chk("res_queue_empty", exp_res.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
